// File: rtl/cpu_types_pkg.sv
// Shared CPU/cache types: word type, dcache address breakdown and snoop FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SUPPLY0,
    SUPPLY1,
    UPDATE,
    DONE
  } snoop_state_t;

endpackage

// File: rtl/snoop_tag_match.sv
// Combinational WAYS-way tag compare for the snoop responder.
// Scans from the highest way down so the lowest-numbered hitting way wins.
module snoop_tag_match
  import cpu_types_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [DTAG_W-1:0] tag,
  input  logic [DTAG_W-1:0] way_tag   [WAYS],
  input  logic              way_valid [WAYS],
  input  logic              way_dirty [WAYS],
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic              hit_dirty
);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_dirty = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == tag)) begin
        hit       = 1'b1;
        hit_way   = WAY_W'(w);
        hit_dirty = way_dirty[w];
      end
    end
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// L1 dcache snoop responder: looks up snooped blocks, supplies dirty data cache-to-cache
// and downgrades (M->S) or invalidates the block. Optional SNOOP_COUNTERS_EN adds hit/c2c counters.
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 8,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ccwait,
  input  logic              ccinv,
  input  word_t             ccsnoopaddr,
  input  logic              dwait,
  output logic              ccwrite,
  output word_t             snoop_dstore,
  output logic              snoop_busy,
  output logic [IDX_W-1:0]  tag_idx,
  input  logic [DTAG_W-1:0] way_tag   [WAYS],
  input  logic              way_valid [WAYS],
  input  logic              way_dirty [WAYS],
  output logic [WAY_W-1:0]  data_way,
  output logic              data_blkoff,
  input  word_t             data_rdata,
  output logic              upd_en,
  output logic [IDX_W-1:0]  upd_idx,
  output logic [WAY_W-1:0]  upd_way,
  output logic              upd_valid,
  output logic              upd_dirty
`ifdef SNOOP_COUNTERS_EN
  ,
  output logic [31:0]       snoop_hit_count,
  output logic [31:0]       c2c_count
`endif
);

  snoop_state_t      state, next_state;
  logic [DTAG_W-1:0] tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic              inv_q;
  logic [WAY_W-1:0]  way_q;

  dcachef_t          snoop_f;
  logic              unused_offsets;
  logic              hit, hit_dirty;
  logic [WAY_W-1:0]  hit_way;

  assign snoop_f        = dcachef_t'(ccsnoopaddr);
  assign unused_offsets = ^{snoop_f.blkoff, snoop_f.bytoff};

  snoop_tag_match #(.WAYS(WAYS), .WAY_W(WAY_W)) u_match (
    .tag       (tag_q),
    .way_tag   (way_tag),
    .way_valid (way_valid),
    .way_dirty (way_dirty),
    .hit       (hit),
    .hit_way   (hit_way),
    .hit_dirty (hit_dirty)
  );

  // Address and ccinv are captured only on request acceptance; later changes are ignored.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      tag_q <= '0;
      idx_q <= '0;
      inv_q <= 1'b0;
      way_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && ccwait) begin
        tag_q <= snoop_f.tag;
        idx_q <= IDX_W'(snoop_f.idx);
        inv_q <= ccinv;
      end
      if (state == LOOKUP && hit) begin
        way_q <= hit_way;
      end
    end
  end

  always_comb begin
    next_state   = state;
    ccwrite      = 1'b0;
    snoop_dstore = '0;
    tag_idx      = '0;
    data_way     = '0;
    data_blkoff  = 1'b0;
    upd_en       = 1'b0;
    upd_idx      = '0;
    upd_way      = '0;
    upd_valid    = 1'b0;
    upd_dirty    = 1'b0;
    snoop_busy   = (state != IDLE) | ccwait;

    unique case (state)
      IDLE: begin
        if (ccwait) next_state = LOOKUP;
      end
      LOOKUP: begin
        tag_idx = idx_q;
        if (!ccwait)                next_state = IDLE;
        else if (hit && hit_dirty)  next_state = SUPPLY0;
        else if (hit && inv_q)      next_state = UPDATE;
        else                        next_state = DONE;
      end
      SUPPLY0, SUPPLY1: begin
        tag_idx      = idx_q;
        ccwrite      = 1'b1;
        data_way     = way_q;
        data_blkoff  = (state == SUPPLY1);
        snoop_dstore = data_rdata;
        if (!ccwait)     next_state = IDLE;
        else if (!dwait) next_state = (state == SUPPLY0) ? SUPPLY1 : UPDATE;
      end
      UPDATE: begin
        // A read snoop leaves the block Shared; an invalidating snoop drops it.
        tag_idx    = idx_q;
        upd_en     = 1'b1;
        upd_idx    = idx_q;
        upd_way    = way_q;
        upd_valid  = ~inv_q;
        next_state = DONE;
      end
      DONE: begin
        tag_idx = idx_q;
        if (!ccwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef SNOOP_COUNTERS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_hit_count <= '0;
      c2c_count       <= '0;
    end else begin
      if (state == LOOKUP && hit)                     snoop_hit_count <= snoop_hit_count + 32'd1;
      if (state == SUPPLY1 && next_state == UPDATE)   c2c_count       <= c2c_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench for dcache_snoop_responder: a tag/data array model feeds the DUT and a
// scoreboard of expected supplied words and state updates is drained by a negedge monitor.
module tb_dcache_snoop_responder;
  import cpu_types_pkg::*;

  localparam int WAYS = 2;
  localparam int SETS = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ccwait, ccinv, dwait;
  word_t       ccsnoopaddr;
  logic        ccwrite, snoop_busy, data_blkoff, upd_en, upd_valid, upd_dirty;
  word_t       snoop_dstore, data_rdata;
  logic [2:0]  tag_idx, upd_idx;
  logic        data_way, upd_way;
  logic [25:0] wayTag   [WAYS];
  logic        wayValid [WAYS];
  logic        wayDirty [WAYS];
`ifdef SNOOP_COUNTERS_EN
  logic [31:0] snoopHitCount, c2cCount;
`endif

  logic [25:0] mTag   [SETS][WAYS];
  logic        mValid [SETS][WAYS];
  logic        mDirty [SETS][WAYS];
  word_t       mData  [SETS][WAYS][2];

  int          errors = 0;
  int          checks = 0;
  int          updCount = 0;
  int          ccwriteCount = 0;
  word_t       supQ[$];
  logic [5:0]  updQ[$];

  always #5 CLK = ~CLK;

  dcache_snoop_responder #(.WAYS(WAYS), .SETS(SETS)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ccwait       (ccwait),
    .ccinv        (ccinv),
    .ccsnoopaddr  (ccsnoopaddr),
    .dwait        (dwait),
    .ccwrite      (ccwrite),
    .snoop_dstore (snoop_dstore),
    .snoop_busy   (snoop_busy),
    .tag_idx      (tag_idx),
    .way_tag      (wayTag),
    .way_valid    (wayValid),
    .way_dirty    (wayDirty),
    .data_way     (data_way),
    .data_blkoff  (data_blkoff),
    .data_rdata   (data_rdata),
    .upd_en       (upd_en),
    .upd_idx      (upd_idx),
    .upd_way      (upd_way),
    .upd_valid    (upd_valid),
    .upd_dirty    (upd_dirty)
`ifdef SNOOP_COUNTERS_EN
    ,
    .snoop_hit_count (snoopHitCount),
    .c2c_count       (c2cCount)
`endif
  );

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      wayTag[w]   = mTag[tag_idx][w];
      wayValid[w] = mValid[tag_idx][w];
      wayDirty[w] = mDirty[tag_idx][w];
    end
  end

  assign data_rdata = mData[tag_idx][data_way][data_blkoff];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every accepted word and every update strobe must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ccwrite) ccwriteCount++;
      if (ccwrite && !dwait) begin
        if (supQ.size() == 0) checkOutput("sup_unexpected", supQ.size(), 1);
        else                  checkOutput("sup_word", snoop_dstore, supQ.pop_front());
      end
      if (upd_en) begin
        updCount++;
        if (updQ.size() == 0) checkOutput("upd_unexpected", updQ.size(), 1);
        else checkOutput("upd_fields", {upd_idx, upd_way, upd_valid, upd_dirty}, updQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic inv, input word_t addr);
    @(posedge CLK);
    #1;
    ccwait      = w;
    ccinv       = inv;
    ccsnoopaddr = addr;
  endtask

  task automatic setLine(input int idx, input int way, input logic [25:0] tag, input logic v,
                         input logic d, input word_t w0, input word_t w1);
    mTag[idx][way]      = tag;
    mValid[idx][way]    = v;
    mDirty[idx][way]    = d;
    mData[idx][way][0]  = w0;
    mData[idx][way][1]  = w1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (supQ.size() + updQ.size()) != 0; i++) @(negedge CLK);
    checkOutput("drain", supQ.size() + updQ.size(), 0);
  endtask

  task automatic endSnoop(input string tag);
    applyStimulus(1'b0, 1'b0, '0);
    @(negedge CLK);
    checkOutput({tag, "_done_busy"}, snoop_busy, 1);
    @(negedge CLK);
    checkOutput({tag, "_idle_busy"}, snoop_busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prevWr, prevUpd;
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccsnoopaddr = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) setLine(s, w, '0, 1'b0, 1'b0, '0, '0);

    #3;
    checkOutput("rst_ccwrite", ccwrite, 0);
    checkOutput("rst_busy", snoop_busy, 0);
    checkOutput("rst_upd_en", upd_en, 0);
    checkOutput("rst_tag_idx", tag_idx, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Miss: nothing at idx 0 is valid.
    prevWr = ccwriteCount; prevUpd = updCount;
    applyStimulus(1'b1, 1'b0, 32'h0000_1040);
    #1 checkOutput("miss_busy_comb", snoop_busy, 1);
    @(negedge CLK); @(negedge CLK);
    checkOutput("miss_lookup_idx", tag_idx, 0);
    @(negedge CLK);
    checkOutput("miss_ccwrite", ccwrite, 0);
    endSnoop("miss");
    checkOutput("miss_no_wr", ccwriteCount - prevWr, 0);
    checkOutput("miss_no_upd", updCount - prevUpd, 0);

    // Dirty read hit with a decoy valid line in way 0; a late ccinv change must be ignored.
    setLine(4, 0, 26'h41, 1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321);
    setLine(4, 1, 26'h40, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    supQ.push_back(32'hDEAD_BEEF);
    supQ.push_back(32'hCAFE_F00D);
    updQ.push_back({3'd4, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 32'h0000_1020);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rd_lookup_wr", ccwrite, 0);
    checkOutput("rd_lookup_idx", tag_idx, 4);
    ccinv = 1'b1;
    @(negedge CLK);
    checkOutput("rd_t2_wr", ccwrite, 1);
    checkOutput("rd_t2_way", data_way, 1);
    drain();
    endSnoop("rd");

    // Dirty invalidating hit: word 0 stalled by dwait for three cycles.
    setLine(2, 0, 26'h77, 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002);
    supQ.push_back(32'hA5A5_0001);
    supQ.push_back(32'h5A5A_0002);
    updQ.push_back({3'd2, 1'b0, 1'b0, 1'b0});
    dwait = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0000_1DD0);
    @(negedge CLK); @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("inv_hold_wr", ccwrite, 1);
      checkOutput("inv_hold_w0", snoop_dstore, 32'hA5A5_0001);
    end
    @(posedge CLK);
    #1 dwait = 1'b0;
    drain();
    endSnoop("inv");

    // Clean invalidating hit; both ways match, the lower (clean) way must win.
    setLine(5, 0, 26'h12, 1'b1, 1'b0, 32'h0, 32'h0);
    setLine(5, 1, 26'h12, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    updQ.push_back({3'd5, 1'b0, 1'b0, 1'b0});
    prevWr = ccwriteCount;
    applyStimulus(1'b1, 1'b1, 32'h0000_04A8);
    @(negedge CLK); @(negedge CLK);
    checkOutput("cln_t1_upd", upd_en, 0);
    @(negedge CLK);
    checkOutput("cln_t2_upd", upd_en, 1);
    checkOutput("cln_t2_valid", upd_valid, 0);
    drain();
    checkOutput("cln_no_wr", ccwriteCount - prevWr, 0);
    endSnoop("cln");

    // Abort during SUPPLY1: word 0 transfers, then ccwait drops.
    setLine(6, 1, 26'h05, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
    supQ.push_back(32'h1111_1111);
    prevUpd = updCount;
    applyStimulus(1'b1, 1'b0, 32'h0000_0170);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    @(posedge CLK);
    #1;
    ccwait = 1'b0;
    dwait  = 1'b1;
    @(negedge CLK);
    checkOutput("abort_wr_hold", ccwrite, 1);
    @(negedge CLK);
    checkOutput("abort_wr_drop", ccwrite, 0);
    checkOutput("abort_busy", snoop_busy, 0);
    checkOutput("abort_no_upd", updCount - prevUpd, 0);
    drain();

    // Reset pulsed while in SUPPLY0.
    applyStimulus(1'b1, 1'b0, 32'h0000_0170);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    checkOutput("pre_rst_wr", ccwrite, 1);
`ifdef SNOOP_COUNTERS_EN
    checkOutput("pre_rst_hits", snoopHitCount, 5);
    checkOutput("pre_rst_c2c", c2cCount, 2);
`endif
    #1;
    nRST   = 1'b0;
    ccwait = 1'b0;
    #1;
    checkOutput("rst_mid_wr", ccwrite, 0);
    checkOutput("rst_mid_busy", snoop_busy, 0);
    checkOutput("rst_mid_dstore", snoop_dstore, 0);
    checkOutput("rst_mid_idx", tag_idx, 0);
`ifdef SNOOP_COUNTERS_EN
    checkOutput("rst_mid_hits", snoopHitCount, 0);
    checkOutput("rst_mid_c2c", c2cCount, 0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("post_rst_busy", snoop_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
